top_neurons: RTL and testbench

Array of NUM_NEURON Ising-style spiking neurons with a single 16-bit word-serial load/command port and a spin readback port. The host first streams each neuron's membrane offset (Vmem), FP16 bias (mu), neuron ID and ternary coupling row (Q). It then issues anneal commands, each of which performs one sequential sweep of spin updates. The block sits between the host I/O pads and the annealing core; it is the top level of the neuron fabric.

---
 rtl/top_neurons.sv | 170 +++++++++++++++++
 tb/tb_top_neurons.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/top_neurons.sv
// Ising-style spiking neuron array with a 16-bit word-serial load/command port and spin readback.
// Optional NEURON_MU_BIAS_EN: add the truncated FP16 bias mu to each neuron's field.
module top_neurons #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NUM_NEURON      = 4,
    parameter int NEURON_ID_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        rd,
    input  logic [15:0] ins,
    output logic [15:0] outs
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SWEEP = 2'd2} state_t;

    localparam int IW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    localparam int WW = $clog2(NUM_NEURON + 3);
    localparam logic [WW-1:0] LAST_W = WW'(NUM_NEURON + 2);
    localparam logic [IW-1:0] LAST_N = IW'(NUM_NEURON - 1);

    state_t state, next_state;
    logic [IW-1:0] n_idx;
    logic [WW-1:0] w_idx;
    logic [WW-1:0] q_col;

    logic signed [15:0]          vmem      [NUM_NEURON];
    logic [FP_DATA_WIDTH-1:0]    mu        [NUM_NEURON];
    logic [NEURON_ID_WIDTH-1:0]  neuron_id [NUM_NEURON];
    logic [TEN_DATA_WIDTH-1:0]   q_ram     [NUM_NEURON][NUM_NEURON];
    logic [NUM_NEURON-1:0]       spin;

    logic start_load, start_sweep, load_last, sweep_last, busy;
    logic signed [19:0] field;
    logic field_pos, field_neg;
    logic [15:0] outs_next;
    logic unused_bits;

`ifdef NEURON_MU_BIAS_EN
    // Truncate toward zero; Inf/NaN and |mu| < 1 (incl. subnormals) give 0.
    function automatic logic signed [15:0] fp16_to_int(input logic [15:0] h);
        logic [4:0]  e;
        logic [15:0] mag;
        e   = h[14:10];
        mag = '0;
        if (e == 5'd31 || e < 5'd15) mag = '0;
        else if (e >= 5'd30)         mag = 16'd32767;
        else if (e >= 5'd25)         mag = {5'd0, 1'b1, h[9:0]} << (e - 5'd25);
        else                         mag = {5'd0, 1'b1, h[9:0]} >> (5'd25 - e);
        return h[15] ? -$signed(mag) : $signed(mag);
    endfunction
`endif

    // State register
    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_load) next_state = LOAD;
                     else if (start_sweep) next_state = SWEEP;
            LOAD:    if (load_last) next_state = IDLE;
            SWEEP:   if (sweep_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        start_load  = (state == IDLE) && (ins == 16'h0001);
        start_sweep = (state == IDLE) && (ins == 16'h6060);
        load_last   = (state == LOAD) && (w_idx == LAST_W) && (n_idx == LAST_N);
        sweep_last  = (state == SWEEP) && (n_idx == LAST_N);
        busy        = (state != IDLE);
    end

    // rd is a one-cycle sample request with no ready: every edge with rd = 1 captures
    // {busy, spins} as they were before that edge; rd = 0 holds outs.
    always_comb begin
        outs_next = '0;
        outs_next[NUM_NEURON-1:0] = spin;
        outs_next[15] = busy;
    end

    // Field of the neuron being swept; diagonal coupling is skipped.
    always_comb begin
        field = {{4{vmem[n_idx][15]}}, vmem[n_idx]};
        for (int j = 0; j < NUM_NEURON; j++) begin
            if (j != int'(n_idx)) begin
                if (q_ram[n_idx][j] == TEN_DATA_WIDTH'(1))
                    field = spin[j] ? field + 20'sd1 : field - 20'sd1;
                else if (q_ram[n_idx][j] == TEN_DATA_WIDTH'(2))
                    field = spin[j] ? field - 20'sd1 : field + 20'sd1;
            end
        end
`ifdef NEURON_MU_BIAS_EN
        field = field + 20'(fp16_to_int(mu[n_idx]));
`endif
        field_pos = !field[19] && (field != 20'sd0);
        field_neg = field[19];
    end

    assign q_col = w_idx - WW'(3);

    // Stored for host bookkeeping only; nothing in the update reads these.
    always_comb begin
        unused_bits = 1'b0;
        for (int n = 0; n < NUM_NEURON; n++) begin
            unused_bits = unused_bits ^ (^neuron_id[n]);
`ifndef NEURON_MU_BIAS_EN
            unused_bits = unused_bits ^ (^mu[n]);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) begin
            outs  <= '0;
            n_idx <= '0;
            w_idx <= '0;
            spin  <= '0;
            for (int n = 0; n < NUM_NEURON; n++) begin
                vmem[n]      <= '0;
                mu[n]        <= '0;
                neuron_id[n] <= '0;
                for (int j = 0; j < NUM_NEURON; j++) q_ram[n][j] <= '0;
            end
        end else begin
            if (rd) outs <= outs_next;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        n_idx <= '0;
                        w_idx <= '0;
                        spin  <= '0;
                    end else if (start_sweep) begin
                        n_idx <= '0;
                    end
                end
                LOAD: begin
                    case (w_idx)
                        WW'(0):  vmem[n_idx]      <= ins;
                        WW'(1):  mu[n_idx]        <= ins[FP_DATA_WIDTH-1:0];
                        WW'(2):  neuron_id[n_idx] <= ins[NEURON_ID_WIDTH-1:0];
                        default: begin
                            for (int j = 0; j < NUM_NEURON; j++)
                                if (q_col == WW'(j)) q_ram[n_idx][j] <= ins[TEN_DATA_WIDTH-1:0];
                        end
                    endcase
                    if (w_idx == LAST_W) begin
                        w_idx <= '0;
                        n_idx <= load_last ? '0 : n_idx + IW'(1);
                    end else begin
                        w_idx <= w_idx + WW'(1);
                    end
                end
                SWEEP: begin
                    if (field_pos)      spin[n_idx] <= 1'b1;
                    else if (field_neg) spin[n_idx] <= 1'b0;
                    n_idx <= sweep_last ? '0 : n_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_top_neurons.sv
// Directed bench for top_neurons: reset, load, sweep, ignored commands, reset during load.
module tb_top_neurons;
    logic        clk = 1'b0;
    logic        reset_l;
    logic        rd;
    logic [15:0] ins;
    logic [15:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] tv [4] = '{16'h0004, 16'h0005, 16'hFFFA, 16'h0001};
    logic [15:0] tm [4] = '{16'h4300, 16'h4540, 16'hC266, 16'hABAE};
    logic [1:0]  tq [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd0},
                               '{2'd2, 2'd0, 2'd1, 2'd2},
                               '{2'd1, 2'd2, 2'd0, 2'd1},
                               '{2'd0, 2'd1, 2'd2, 2'd0}};

    top_neurons dut (
        .clk     (clk),
        .reset_l (reset_l),
        .rd      (rd),
        .ins     (ins),
        .outs    (outs)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic send(input logic [15:0] w);
        ins = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] load_word(input int n, input int w);
        logic [15:0] r;
        if (w == 0)      r = tv[n];
        else if (w == 1) r = tm[n];
        else if (w == 2) r = 16'(n);
        else             r = {14'd0, tq[n][w-3]};
        return r;
    endfunction

    task automatic test_reset();
        reset_l = 1'b1; rd = 1'b0; ins = 16'h0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (outs !== 16'h0000) $display("FAIL reset_outs: got %h want 0000", outs);
        else n_pass++;
        reset_l = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut.state);
        else n_pass++;
        for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (dut.vmem[n] !== 16'h0000 || dut.mu[n] !== 16'h0000)
                $display("FAIL reset_regs n%0d: vmem %h mu %h want 0", n, dut.vmem[n], dut.mu[n]);
            else n_pass++;
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (dut.q_ram[n][j] !== 2'd0) $display("FAIL reset_q[%0d][%0d]: got %0d want 0", n, j, dut.q_ram[n][j]);
                else n_pass++;
            end
        end
        rd = 1'b1;
        send(16'h0000);
        rd = 1'b0;
        n_checks++;
        if (outs !== 16'h0000) $display("FAIL reset_rd: got %h want 0000", outs);
        else n_pass++;
    endtask

    task automatic test_load();
        send(16'h0001);
        for (int n = 0; n < 4; n++) begin
            for (int w = 0; w < 7; w++) begin
                if (n == 1 && w == 0) rd = 1'b1;
                send(load_word(n, w));
                if (n == 1 && w == 0) begin
                    rd = 1'b0;
                    n_checks++;
                    if (outs !== 16'h8000) $display("FAIL load_busy: got %h want 8000", outs);
                    else n_pass++;
                end
            end
        end
        ins = 16'h0000;
        n_checks++;
        if (dut.state !== 2'd0) $display("FAIL load_done_state: got %0d want 0", dut.state);
        else n_pass++;
        n_checks++;
        if (dut.spin !== 4'h0) $display("FAIL load_spins: got %h want 0", dut.spin);
        else n_pass++;
        for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (dut.vmem[n] !== tv[n]) $display("FAIL load_vmem n%0d: got %h want %h", n, dut.vmem[n], tv[n]);
            else n_pass++;
            n_checks++;
            if (dut.mu[n] !== tm[n]) $display("FAIL load_mu n%0d: got %h want %h", n, dut.mu[n], tm[n]);
            else n_pass++;
            n_checks++;
            if (dut.neuron_id[n] !== 2'(n)) $display("FAIL load_id n%0d: got %0d want %0d", n, dut.neuron_id[n], n);
            else n_pass++;
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (dut.q_ram[n][j] !== tq[n][j])
                    $display("FAIL load_q[%0d][%0d]: got %0d want %0d", n, j, dut.q_ram[n][j], tq[n][j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sweep();
        // Readback each edge from the command edge onward: pre-edge spins and busy.
        logic [15:0] exp_seq [6] = '{16'h0000, 16'h8000, 16'h8001, 16'h8003, 16'h8003, 16'h000B};
        rd = 1'b1;
        send(16'h6060);
        n_checks++;
        if (outs !== exp_seq[0]) $display("FAIL sweep_cmd_edge: got %h want %h", outs, exp_seq[0]);
        else n_pass++;
        for (int i = 1; i < 6; i++) begin
            send(16'h0000);
            n_checks++;
            if (outs !== exp_seq[i]) $display("FAIL sweep_step%0d: got %h want %h", i, outs, exp_seq[i]);
            else n_pass++;
        end
        rd = 1'b0;
    endtask

    task automatic test_ignored_cmds();
        logic [15:0] cmds [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        rd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            send(cmds[c]);
            n_checks++;
            if (outs !== 16'h000B || dut.state !== 2'd0)
                $display("FAIL ignored_%h: outs %h state %0d want 000B state 0", cmds[c], outs, dut.state);
            else n_pass++;
        end
        send(16'h0000);
        n_checks++;
        if (outs !== 16'h000B) $display("FAIL ignored_after: got %h want 000B", outs);
        else n_pass++;
        rd = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        send(16'h0001);
        for (int k = 0; k < 10; k++) send(load_word(k / 7, k % 7));
        ins = load_word(1, 3);
        #2 reset_l = 1'b1;
        #1;
        n_checks++;
        if (outs !== 16'h0000 || dut.state !== 2'd0)
            $display("FAIL midload_reset: outs %h state %0d want 0000 state 0", outs, dut.state);
        else n_pass++;
        n_checks++;
        if (dut.vmem[0] !== 16'h0000 || dut.vmem[1] !== 16'h0000 || dut.q_ram[0][1] !== 2'd0)
            $display("FAIL midload_clear: vmem0 %h vmem1 %h q01 %0d want 0", dut.vmem[0], dut.vmem[1], dut.q_ram[0][1]);
        else n_pass++;
        @(negedge clk);
        reset_l = 1'b0;
        ins = 16'h0000;
        @(negedge clk);
        test_load();
        test_sweep();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load();
        test_sweep();
        test_ignored_cmds();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
